// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL command path: sequencer state
// encoding, LCD_CTRL command codes and image geometry.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_CAPT  = 4'd2,
    S_WAIT  = 4'd3,
    S_ISSUE = 4'd4,
    S_GUARD = 4'd5,
    S_DRAIN = 4'd6,
    S_FIN   = 4'd7,
    S_TOUT  = 4'd8
  } seq_state_e;

  localparam logic [2:0] CMD_WRITE       = 3'd0;
  localparam logic [2:0] CMD_SHIFT_UP    = 3'd1;
  localparam logic [2:0] CMD_SHIFT_DOWN  = 3'd2;
  localparam logic [2:0] CMD_SHIFT_LEFT  = 3'd3;
  localparam logic [2:0] CMD_SHIFT_RIGHT = 3'd4;
  localparam logic [2:0] CMD_ZOOM_IN     = 3'd5;
  localparam logic [2:0] CMD_ZOOM_FIT    = 3'd6;
  localparam logic [2:0] CMD_RESERVED    = 3'd7;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int IMG_PIX = 64;
  localparam int PIX_W   = 8;

  // States in which the sequencer is parked and listens for start.
  function automatic logic seq_at_rest(input seq_state_e s);
    return (s == S_IDLE) || (s == S_FIN) || (s == S_TOUT);
  endfunction

endpackage

// File: rtl/lcd_cmd_seq.sv
// Command initiator for LCD_CTRL: reads commands from a synchronous ROM,
// issues each one when busy is low, and tracks completion, early done and hangs.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int CMD_N  = 45,
  parameter int CMD_AW = 6,
  parameter int TO_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              crom_cen,
  output logic [CMD_AW-1:0] crom_a,
  input  logic [2:0]        crom_q,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_early,
  output logic              seq_err,
  output logic [CMD_AW:0]   issued,
  output seq_state_e        seq_state
);

  // Handshake: cmd_valid is a one-cycle strobe with cmd stable in that cycle.
  // LCD_CTRL accepts it unconditionally and raises busy one cycle later; the
  // GUARD cycle hides that gap so a stale low busy never causes a re-issue.

  localparam logic [CMD_AW:0]   N_CNT  = (CMD_AW+1)'(CMD_N);
  localparam logic [CMD_AW-1:0] A_LAST = CMD_AW'(CMD_N - 1);
  localparam logic [TO_W-1:0]   TO_MAX = '1;

  seq_state_e        state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              crom_cen_q, crom_cen_d;
  logic [CMD_AW-1:0] crom_a_q, crom_a_d;
  logic              seq_busy_q, seq_busy_d;
  logic              done_q, done_d;
  logic              early_q, early_d;
  logic              err_q, err_d;
  logic [CMD_AW:0]   issued_q, issued_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              seen_q, seen_d;
  logic              done_any;

  assign done_any = seen_q | done;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    crom_cen_d  = 1'b1;
    crom_a_d    = crom_a_q;
    seq_busy_d  = 1'b0;
    done_d      = done_q;
    early_d     = early_q;
    err_d       = err_q;
    issued_d    = issued_q;
    to_d        = to_q;
    seen_d      = seen_q;

    if (!seq_at_rest(state_q) && done) begin
      seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_FIN, S_TOUT: begin
        if (start) begin
          state_d  = S_FETCH;
          issued_d = '0;
          done_d   = 1'b0;
          early_d  = 1'b0;
          err_d    = 1'b0;
          seen_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (done_any) begin
          state_d = S_FIN;
          early_d = 1'b1;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (done_any) begin
          state_d = S_FIN;
          early_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cmd_d   = crom_q;
          to_d    = '0;
        end
      end
      S_WAIT: begin
        if (done_any) begin
          state_d = S_FIN;
          early_d = 1'b1;
        end else if (!busy) begin
          state_d = S_ISSUE;
        end else begin
          to_d = to_q + 1'b1;
          if (to_d == TO_MAX) begin
            state_d = S_TOUT;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_GUARD;
        if (issued_q < N_CNT) begin
          issued_d = issued_q + 1'b1;
        end
      end
      S_GUARD: begin
        // A done that arrived with or after this command ends the run here.
        if (done_any) begin
          state_d = S_FIN;
          early_d = (issued_q < N_CNT);
        end else if (issued_q == N_CNT) begin
          state_d = S_DRAIN;
          to_d    = '0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (done_any) begin
          state_d = S_FIN;
        end else begin
          to_d = to_q + 1'b1;
          if (to_d == TO_MAX) begin
            state_d = S_TOUT;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered.
    if (state_d == S_FIN) begin
      done_d = 1'b1;
    end
    if (state_d == S_FETCH) begin
      crom_cen_d = 1'b0;
      crom_a_d   = (issued_d < N_CNT) ? issued_d[CMD_AW-1:0] : A_LAST;
    end
    cmd_valid_d = (state_d == S_ISSUE);
    seq_busy_d  = !seq_at_rest(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      crom_cen_q  <= 1'b1;
      crom_a_q    <= '0;
      seq_busy_q  <= 1'b0;
      done_q      <= 1'b0;
      early_q     <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= '0;
      to_q        <= '0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      crom_cen_q  <= crom_cen_d;
      crom_a_q    <= crom_a_d;
      seq_busy_q  <= seq_busy_d;
      done_q      <= done_d;
      early_q     <= early_d;
      err_q       <= err_d;
      issued_q    <= issued_d;
      to_q        <= to_d;
      seen_q      <= seen_d;
    end
  end

  assign crom_cen  = crom_cen_q;
  assign crom_a    = crom_a_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = done_q;
  assign seq_early = early_q;
  assign seq_err   = err_q;
  assign issued    = issued_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: ROM model, behavioural LCD_CTRL model, pulse
// monitor and a directed/randomized sequence of runs checked against a scoreboard.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  localparam int CMD_N  = 4;
  localparam int CMD_AW = 6;
  localparam int TO_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              crom_cen;
  logic [CMD_AW-1:0] crom_a;
  logic [2:0]        crom_q = '0;
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic              busy = 1'b0;
  logic              done = 1'b0;
  logic              seq_busy, seq_done, seq_early, seq_err;
  logic [CMD_AW:0]   issued;
  seq_state_e        dut_state;

  logic [2:0] rom [0:63];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2:0] pulse_cmd_q[$];
  int         pulse_cyc_q[$];
  logic [2:0] exp_q[$];
  int pulse_base = 0;
  int busy_len = 1;
  int done_at = -1;
  int acc_total = 0;
  int busy_left = 0;

  lcd_cmd_seq #(.CMD_N(CMD_N), .CMD_AW(CMD_AW), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .crom_cen(crom_cen), .crom_a(crom_a), .crom_q(crom_q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_early(seq_early),
    .seq_err(seq_err), .issued(issued), .seq_state(dut_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous command ROM
  always @(posedge clk) if (!crom_cen) crom_q <= rom[crom_a];

  // LCD_CTRL model: busy for busy_len cycles after an accept, done when
  // busy falls after the accept numbered done_at (or at once if busy_len==0).
  always @(negedge clk) begin
    done = 1'b0;
    if (!reset) begin
      busy_left = 0;
    end else if (cmd_valid) begin
      acc_total++;
      if (busy_len == 0) begin
        if (acc_total == done_at) done = 1'b1;
      end else begin
        busy_left = busy_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && acc_total == done_at) done = 1'b1;
    end
    busy = (busy_left > 0);
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (cmd_valid) begin
      pulse_cmd_q.push_back(cmd);
      pulse_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_run(input int n_done, input int blen);
    busy_len   = blen;
    done_at    = acc_total + n_done;
    pulse_base = pulse_cmd_q.size();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while ((pulse_cmd_q.size() - pulse_base) < n && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_pulses", 32'((pulse_cmd_q.size() - pulse_base) >= n), 32'd1);
  endtask

  // Scoreboard: done after command n_done ends the run with n_done commands
  // issued (CMD_N if n_done reaches it), early when fewer than CMD_N.
  task automatic finish_run(input int n_done);
    int k;
    int exp_issued;
    int got;
    k = 0;
    while (seq_busy && k < 300) begin
      step(1);
      k++;
    end
    chk("fin_reached", seq_busy, 32'd0);
    exp_issued = (n_done >= CMD_N) ? CMD_N : n_done;
    chk("fin_done", seq_done, 32'd1);
    chk("fin_early", seq_early, 32'(n_done < CMD_N));
    chk("fin_err", seq_err, 32'd0);
    chk("fin_issued", 32'(issued), 32'(exp_issued));
    chk("fin_valid_low", cmd_valid, 32'd0);
    exp_q.delete();
    for (int i = 0; i < exp_issued; i++) exp_q.push_back(rom[i]);
    got = pulse_cmd_q.size() - pulse_base;
    chk("n_pulses", 32'(got), 32'(exp_issued));
    for (int i = 0; i < got && exp_q.size() > 0; i++) begin
      chk("cmd_order", 32'(pulse_cmd_q[pulse_base + i]), 32'(exp_q.pop_front()));
      if (i > 0)
        chk("spacing", 32'((pulse_cyc_q[pulse_base + i] - pulse_cyc_q[pulse_base + i - 1]) >= 4), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 3'd7;

    // Reset state
    step(3);
    chk("rst_valid", cmd_valid, 32'd0);
    chk("rst_cen", crom_cen, 32'd1);
    chk("rst_a", 32'(crom_a), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_busy", seq_busy, 32'd0);
    chk("rst_flags", {seq_done, seq_early, seq_err}, 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    reset = 1'b1;
    step(2);

    // Nominal run
    rom[0] = 3'd1; rom[1] = 3'd5; rom[2] = 3'd3; rom[3] = 3'd0;
    start_run(CMD_N, 3);
    chk("nom_first_fetch_cen", crom_cen, 32'd0);
    chk("nom_first_fetch_a", 32'(crom_a), 32'd0);
    finish_run(CMD_N);
    step(3);

    // Busy low except for the registered rise, and never-busy
    start_run(CMD_N, 1);
    finish_run(CMD_N);
    step(2);
    start_run(CMD_N, 0);
    finish_run(CMD_N);
    step(2);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int nd;
      int bl;
      for (int i = 0; i < CMD_N; i++) rom[i] = 3'($urandom_range(0, 7));
      nd = $urandom_range(1, CMD_N);
      bl = $urandom_range(0, 5);
      start_run(nd, bl);
      finish_run(nd);
      step($urandom_range(1, 4));
    end

    // Early done
    rom[0] = 3'd0; rom[1] = 3'd1; rom[2] = 3'd2; rom[3] = 3'd7;
    start_run(1, 3);
    finish_run(1);
    step(3);

    // Restart from FIN, then a start while busy must be ignored
    rom[0] = 3'd6; rom[1] = 3'd2; rom[2] = 3'd4; rom[3] = 3'd1;
    start_run(CMD_N, 2);
    chk("rs_cen", crom_cen, 32'd0);
    chk("rs_a", 32'(crom_a), 32'd0);
    chk("rs_flags", {seq_done, seq_early, seq_err}, 32'd0);
    chk("rs_issued", 32'(issued), 32'd0);
    chk("rs_busy", seq_busy, 32'd1);
    step(6);
    chk("rs_busy_mid", seq_busy, 32'd1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    finish_run(CMD_N);
    step(3);

    // Reset during the ISSUE of the fourth command
    for (int i = 0; i < CMD_N; i++) rom[i] = 3'($urandom_range(0, 7));
    start_run(99, 1);
    wait_pulses(4, 100);
    chk("mid_valid", cmd_valid, 32'd1);
    chk("mid_issued", 32'(issued), 32'd3);
    reset = 1'b0;
    step(1);
    chk("mid_rst_valid", cmd_valid, 32'd0);
    chk("mid_rst_issued", 32'(issued), 32'd0);
    chk("mid_rst_cen", crom_cen, 32'd1);
    chk("mid_rst_busy", seq_busy, 32'd0);
    reset = 1'b1;
    step(30);
    chk("mid_no_issue", 32'(pulse_cmd_q.size() - pulse_base), 32'd4);
    chk("mid_idle", seq_busy, 32'd0);

    // Hang: busy stuck high after the first accept
    start_run(99, 10000);
    wait_pulses(1, 50);
    begin
      int k;
      k = 0;
      while (crom_cen && k < 20) begin
        step(1);
        k++;
      end
      chk("hang_fetch_seen", crom_cen, 32'd0);
    end
    step(2);   // now in the first cycle of WAIT
    step(14);
    chk("hang_err_not_yet", seq_err, 32'd0);
    step(1);
    chk("hang_err", seq_err, 32'd1);
    chk("hang_valid", cmd_valid, 32'd0);
    chk("hang_busy", seq_busy, 32'd0);
    chk("hang_issued", 32'(issued), 32'd1);
    chk("hang_pulses", 32'(pulse_cmd_q.size() - pulse_base), 32'd1);
    reset = 1'b0;
    step(1);
    chk("hang_rst_err", seq_err, 32'd0);
    reset = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
